fir_stream_sequencer: RTL and testbench

//  Producer end of the FIR input stream (x_n / s_axis_fir_tvalid / s_set_coeffs).

---
 rtl/fir_stream_sequencer.sv | 144 ++++++++++++++
 tb/tb_fir_stream_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_sequencer.sv
// fir_stream_sequencer
//   Producer end of the FIR input stream. The host fills a coefficient table and a
//   sample buffer while idle. On start the block emits a back-to-back coefficient
//   burst (s_set_coeffs=1), then paced samples (one every period+1 cycles). Playback
//   is one-shot (ends with a done pulse) or loops over the buffer until stop.
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   cfg_we/sel/addr/data: table (sel=1) / buffer (sel=0) write, honoured only when idle
//   start, stop         : begin sequence (idle only) / abort sequence
//   loop, period, len   : playback mode, sample interval minus one, pass length (0=DEPTH)
//   x_n, s_axis_fir_tvalid, s_set_coeffs : registered FIR stream, x_n=0 when not valid
//   busy, done          : sequence in progress / one-cycle one-shot completion pulse
module fir_stream_sequencer #(
  parameter int DATA_W   = 6,
  parameter int NUM_TAPS = 4,
  parameter int DEPTH    = 16,
  parameter int DIV_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [3:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [DIV_W-1:0]  period,
  input  logic [4:0]        len,
  output logic [DATA_W-1:0] x_n,
  output logic              s_axis_fir_tvalid,
  output logic              s_set_coeffs,
  output logic              busy,
  output logic              done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int TW = $clog2(NUM_TAPS + 1);
  localparam int LW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD_COEF, STREAM} state_t;

  state_t            state;
  logic [DATA_W-1:0] coef [NUM_TAPS];
  logic [DATA_W-1:0] mem  [DEPTH];
  logic [TW-1:0]     cidx;        // next coefficient to emit
  logic [LW-1:0]     sidx;        // samples emitted so far in this pass
  logic [LW-1:0]     lat_len;
  logic              lat_loop;
  logic [DIV_W-1:0]  lat_period;
  logic [DIV_W-1:0]  cnt;         // cycles left before the next sample slot
  logic [AW-1:0]     widx;

  // A completed pass (only reachable when looping) restarts at entry 0.
  assign widx = (sidx == lat_len) ? '0 : sidx[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      x_n               <= '0;
      s_axis_fir_tvalid <= 1'b0;
      s_set_coeffs      <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      cidx              <= '0;
      sidx              <= '0;
      lat_len           <= '0;
      lat_loop          <= 1'b0;
      lat_period        <= '0;
      cnt               <= '0;
      for (int i = 0; i < NUM_TAPS; i++) coef[i] <= '0;
      for (int i = 0; i < DEPTH; i++)    mem[i]  <= '0;
    end else begin
      // Stream outputs are single-cycle; anything not re-asserted below drops to 0.
      x_n               <= '0;
      s_axis_fir_tvalid <= 1'b0;
      s_set_coeffs      <= 1'b0;
      done              <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_we) begin
            if (cfg_sel) coef[cfg_addr[CW-1:0]] <= cfg_data;
            else         mem[cfg_addr[AW-1:0]]  <= cfg_data;
          end
          if (start && !stop) begin
            // First coefficient goes out on the same edge that accepts start.
            state             <= LOAD_COEF;
            busy              <= 1'b1;
            x_n               <= coef[0];
            s_axis_fir_tvalid <= 1'b1;
            s_set_coeffs      <= 1'b1;
            cidx              <= TW'(1);
            lat_loop          <= loop;
            lat_period        <= period;
            if (len == 5'd0 || int'(len) > DEPTH) lat_len <= LW'(DEPTH);
            else                                  lat_len <= LW'(len);
          end
        end
        LOAD_COEF: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cidx == TW'(NUM_TAPS)) begin
            // Burst finished: sample[0] follows immediately, then the pacing counter runs.
            state             <= STREAM;
            x_n               <= mem[0];
            s_axis_fir_tvalid <= 1'b1;
            sidx              <= LW'(1);
            cnt               <= lat_period;
          end else begin
            x_n               <= coef[cidx[CW-1:0]];
            s_axis_fir_tvalid <= 1'b1;
            s_set_coeffs      <= 1'b1;
            cidx              <= cidx + TW'(1);
          end
        end
        STREAM: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (sidx == lat_len && !lat_loop) begin
            // Completion is the cycle right after the final sample, independent of period.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cnt == '0) begin
            x_n               <= mem[widx];
            s_axis_fir_tvalid <= 1'b1;
            sidx              <= LW'(widx) + LW'(1);
            cnt               <= lat_period;
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// tb_fir_stream_sequencer
//   Scoreboard bench: each run computes its expected word stream (cycle stamp, value,
//   coefficient flag), done pulse and busy window from the playback rules, and a
//   monitor compares those against the DUT every cycle.
module tb_fir_stream_sequencer;
  localparam int DATA_W = 6;
  localparam int NT     = 4;
  localparam int DEPTH  = 16;
  localparam int DIV_W  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_we = 1'b0, cfg_sel = 1'b0;
  logic [3:0]        cfg_addr = '0;
  logic [DATA_W-1:0] cfg_data = '0;
  logic              start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [DIV_W-1:0]  period = '0;
  logic [4:0]        len = '0;
  logic [DATA_W-1:0] x_n;
  logic              tvalid, set_coeffs, busy, done;

  fir_stream_sequencer #(.DATA_W(DATA_W), .NUM_TAPS(NT), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .stop(stop), .loop(loop), .period(period),
    .len(len), .x_n(x_n), .s_axis_fir_tvalid(tvalid), .s_set_coeffs(set_coeffs),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int stamp; logic [DATA_W-1:0] x; logic set;} word_t;
  word_t exp_q[$];
  int    done_q[$];
  int    busy_lo = 1, busy_hi = 0;
  int    tests = 0, fails = 0;
  bit    chk_en = 0;
  logic [DATA_W-1:0] coef_m [NT];
  logic [DATA_W-1:0] mem_m  [DEPTH];

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, expv);
    end
  endtask

  task automatic flag_fail(string name, int val);
    tests++;
    fails++;
    $display("FAIL %s cyc=%0d got=%0d expected=none", name, cyc, val);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (chk_en) begin
      while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
        flag_fail("missed_word", exp_q[0].stamp);
        void'(exp_q.pop_front());
      end
      while (done_q.size() > 0 && done_q[0] < cyc) begin
        flag_fail("missed_done", done_q[0]);
        void'(done_q.pop_front());
      end
      if (tvalid === 1'b1) begin
        if (exp_q.size() == 0) flag_fail("unexpected_word", x_n);
        else begin
          word_t w;
          w = exp_q.pop_front();
          check("word_cycle", cyc, w.stamp);
          check("x_n", x_n, w.x);
          check("set_coeffs", set_coeffs, w.set);
        end
      end else begin
        check("tvalid_known", tvalid, 0);
        check("x_n_zero", x_n, 0);
        check("set_coeffs_zero", set_coeffs, 0);
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) flag_fail("unexpected_done", cyc);
        else check("done_cycle", cyc, done_q.pop_front());
      end else check("done_low", done, 0);
      check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NT; i++) coef_m[i] = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  // idle=1 means the block is idle so the write must land in the model too.
  task automatic cfg_wr(input bit sel, input int addr, input int data, input bit idle);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 4'(addr); cfg_data = DATA_W'(data);
    if (idle) begin
      if (sel) coef_m[addr % NT] = DATA_W'(data);
      else     mem_m[addr] = DATA_W'(data);
    end
    tick();
    cfg_we = 1'b0;
  endtask

  // One playback. cut>0: stop (or reset) driven cut cycles after start.
  // poke: write sample[0]=63 and re-assert start while busy (both must be ignored).
  task automatic run(input int ln, input int per, input bit lp, input int cut,
                     input bit use_reset, input bit poke);
    int cs, L, limit, stamp, k, last;
    cs = cyc;
    L = (ln == 0 || ln > DEPTH) ? DEPTH : ln;
    limit = (cut > 0) ? cs + cut : 32'h3fff_ffff;
    for (int i = 0; i < NT; i++)
      if (cs + 1 + i <= limit) exp_q.push_back('{cs + 1 + i, coef_m[i], 1'b1});
    k = 0;
    forever begin
      stamp = cs + 1 + NT + k * (per + 1);
      if (stamp > limit || (!lp && k >= L)) break;
      exp_q.push_back('{stamp, mem_m[k % L], 1'b0});
      k++;
    end
    last = cs + 1 + NT + (L - 1) * (per + 1);
    if (!lp && last + 1 <= limit) done_q.push_back(last + 1);
    busy_lo = cs + 1;
    busy_hi = (!lp && last < limit) ? last : limit;

    start = 1'b1; len = 5'(ln); period = DIV_W'(per); loop = lp;
    tick();
    start = 1'b0;
    // Mode inputs are latched at start; scramble them for the rest of the run.
    len = 5'($urandom_range(0, 31)); period = DIV_W'($urandom_range(0, 5)); loop = 1'($urandom);
    if (poke) begin
      cfg_wr(1'b0, 0, 63, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    if (cut > 0) begin
      while (cyc < cs + cut) tick();
      if (use_reset) begin
        reset = 1'b1;
        clear_model();
        tick();
        reset = 1'b0;
      end else begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
      end
    end
    while (cyc <= busy_hi + 2) tick();
    check("words_drained", exp_q.size(), 0);
    check("done_drained", done_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    tick();
    chk_en = 1;
    tick(); tick();
    check("rst_tvalid", tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_x_n", x_n, 0);
    reset = 1'b0;
    tick();

    // Directed cases
    for (int i = 0; i < NT; i++) cfg_wr(1'b1, i, i + 1, 1'b1);
    for (int i = 0; i < DEPTH; i++) cfg_wr(1'b0, i, 10 + i, 1'b1);
    run(3, 0, 0, 0, 0, 0);                // one-shot back-to-back
    run(3, 2, 0, 0, 0, 0);                // paced samples
    run(0, 0, 1, NT + 16 + 8, 0, 0);      // full buffer, wraps, no coef reload
    run(0, 0, 1, NT + 2, 0, 0);           // stop during 2nd sample
    run(3, 0, 0, 0, 0, 0);                // restart replays coefs
    run(5, 1, 0, 0, 0, 1);                // writes/start while busy ignored
    run(3, 0, 0, 0, 0, 0);                // sample[0] still 10
    run(3, 0, 0, 2, 1, 0);                // reset mid coefficient burst
    run(3, 0, 0, 0, 0, 0);                // all-zero memories
    run(1, 3, 0, 0, 0, 0);                // single-sample pass
    run(20, 0, 0, 0, 0, 0);               // len above DEPTH clamps
    run(4, 2, 0, NT + 1 + 3 * 3, 0, 0);   // stop on last sample beats done

    // Randomized runs
    for (int it = 0; it < 30; it++) begin
      int nw, ln, per, cut;
      bit lp, rs, pk;
      nw = $urandom_range(0, 6);
      for (int j = 0; j < nw; j++)
        cfg_wr(1'($urandom), $urandom_range(0, 15), $urandom_range(0, 63), 1'b1);
      ln  = $urandom_range(0, 20);
      per = $urandom_range(0, 3);
      lp  = 1'($urandom);
      cut = lp ? $urandom_range(1, 60) : (($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0);
      rs  = ($urandom_range(0, 5) == 0);
      pk  = (cut == 0 || cut >= 4) && ($urandom_range(0, 3) == 0);
      run(ln, per, lp, cut, rs, pk);
    end

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
